fetch_unit: RTL

Front-end fetch stage of the superscalar LEGv8 core. It owns the architectural fetch PC and issues bundle-sized requests to instruction memory. Returned bundles are buffered in a small fetch queue, and the queue head drives the if_valid/if_pc/if_instr inputs of decode. Fetch predicts not-taken and follows the sequential path until the backend redirects it; it honours decode's fetch_stall_req backpressure without losing or duplicating bundles.

---
 rtl/core_pkg.sv | 13 +
 rtl/fetch_queue.sv | 54 +++++
 rtl/fetch_unit.sv | 105 ++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Core-wide widths and the fetch bundle type shared by the front end.
package core_pkg;

  localparam int XLEN         = 32;
  localparam int FETCH_WIDTH  = 2;
  localparam int BUNDLE_BYTES = 4 * FETCH_WIDTH;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr [FETCH_WIDTH];
  } fetch_bundle_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch bundles; head is visible combinationally.
// Flush wins over push and pop; a push into a full queue or a pop from an empty one is ignored.
module fetch_queue
  import core_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  fetch_bundle_t            push_bundle,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_bundle_t            head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_bundle_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !flush && (count != CW'(DEPTH));
  assign do_pop  = pop && !flush && (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_bundle;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch PC, single-outstanding imem request tracking, stale-response drop, and queue head to decode.
// Requests only issue when a queue slot is reserved for them, so the queue never overflows.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              FQ_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic                        imem_req_valid,
  output logic [XLEN-1:0]             imem_req_addr,
  input  logic                        imem_req_ready,
  input  logic                        imem_resp_valid,
  input  logic [XLEN*FETCH_WIDTH-1:0] imem_resp_data,
  input  logic                        redirect_valid,
  input  logic [XLEN-1:0]             redirect_pc,
  input  logic                        fetch_stall_req,
  output logic [FETCH_WIDTH-1:0]      if_valid,
  output logic [XLEN*FETCH_WIDTH-1:0] if_pc,
  output logic [XLEN*FETCH_WIDTH-1:0] if_instr
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_pc_q;
  logic            out_q;
  logic            drop_q;

  logic [CW-1:0]   count;
  fetch_bundle_t   head;
  fetch_bundle_t   push_bundle;
  logic            nonempty;
  logic            pop;
  logic            resp_live;
  logic            push;
  logic            accept;
  logic [CW:0]     used;

  always_comb begin
    push_bundle.pc = req_pc_q;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      push_bundle.instr[i] = imem_resp_data[i*XLEN +: XLEN];
    end
  end

  assign nonempty  = (count != '0);
  assign pop       = nonempty && !fetch_stall_req;
  assign resp_live = imem_resp_valid && out_q;
  assign push      = resp_live && !drop_q;

  // Slots held by buffered bundles plus the in-flight request, less the one leaving this cycle.
  assign used = {1'b0, count} + {{CW{1'b0}}, out_q} - {{CW{1'b0}}, pop};

  assign imem_req_valid = !reset && !redirect_valid
                          && (used < (CW+1)'(FQ_DEPTH))
                          && (!out_q || push);
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      out_q    <= 1'b0;
      drop_q   <= 1'b0;
    end else if (redirect_valid) begin
      pc_q   <= redirect_pc;
      drop_q <= out_q && !imem_resp_valid;
      out_q  <= out_q && !imem_resp_valid;
    end else begin
      if (accept) begin
        out_q    <= 1'b1;
        pc_q     <= pc_q + XLEN'(BUNDLE_BYTES);
        req_pc_q <= pc_q;
      end else if (resp_live) begin
        out_q <= 1'b0;
      end
      if (resp_live && drop_q) begin
        drop_q <= 1'b0;
      end
    end
  end

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_bundle (push_bundle),
    .pop         (pop),
    .flush       (redirect_valid),
    .head        (head),
    .count       (count)
  );

  for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_lane
    assign if_valid[i]               = nonempty;
    assign if_pc[i*XLEN +: XLEN]     = nonempty ? head.pc + XLEN'(4 * i) : '0;
    assign if_instr[i*XLEN +: XLEN]  = nonempty ? head.instr[i] : '0;
  end

endmodule
